// File: rtl/spi_time_if.sv
// Bus bundle between a time-record requester and spi_time_transmitter:
// request fields, handshake and the SPI pins.
interface spi_time_if;
  logic       start;
  logic       ready;
  logic       header;
  logic [4:0] year;
  logic [3:0] month;
  logic [4:0] day;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       sclk;
  logic       sdo;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, header, year, month, day, hour, minute, second,
    input  ready, sclk, sdo, busy, done, err
  );

  modport slave (
    input  start, header, year, month, day, hour, minute, second,
    output ready, sclk, sdo, busy, done, err
  );
endinterface

// File: rtl/spi_time_transmitter.sv
// SPI master that shifts a 32-bit time/date frame out MSB-first on sclk/sdo.
// Optional macro REPEAT_EN: resend the last latched word after REPEAT_PERIOD idle cycles.
module spi_time_transmitter #(
  parameter int unsigned HALF_PERIOD   = 4,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned REPEAT_PERIOD = 1024
) (
  input  logic       clk,
  input  logic       reset,
  spi_time_if.slave  bus
);

  localparam int unsigned DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned BIT_W = 6;
  localparam int unsigned FRM_W = 32;

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FRM_W-1:0]   shift_q, shift_d;
  logic [FRM_W-1:0]   word_q, word_d;
  logic               sclk_q, sclk_d;
  logic               sdo_q, sdo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  logic [FRM_W-1:0]   frame_c;
  logic               valid_c;
  logic               launch_c;
  logic [FRM_W-1:0]   launch_word_c;
  logic               expire_c;

  assign frame_c = {bus.header, bus.year, bus.month, bus.day,
                    bus.hour, bus.minute, bus.second};

  assign valid_c = (bus.month  >= 4'd1) && (bus.month <= 4'd12) &&
                   (bus.day    >= 5'd1) &&
                   (bus.hour   <= 5'd23) &&
                   (bus.minute <= 6'd59) &&
                   (bus.second <= 6'd59);

`ifdef REPEAT_EN
  localparam int unsigned TMR_W = $clog2(REPEAT_PERIOD + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             sent_q, sent_d;

  assign expire_c = sent_q && (tmr_q == TMR_W'(REPEAT_PERIOD - 1));

  // Idle timer: runs only in IDLE once a frame has gone out; any request clears it.
  always_comb begin
    tmr_d  = '0;
    sent_d = sent_q;
    if (state_q == IDLE) begin
      if (bus.start && valid_c) sent_d = 1'b1;
      if (!bus.start && sent_q && !expire_c) tmr_d = TMR_W'(tmr_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q  <= '0;
      sent_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      sent_q <= sent_d;
    end
  end
`else
  assign expire_c = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    gap_d         = gap_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    word_d        = word_q;
    sclk_d        = sclk_q;
    sdo_d         = sdo_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    launch_c      = 1'b0;
    launch_word_c = frame_c;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (valid_c) begin
            launch_c = 1'b1;
            word_d   = frame_c;
          end else begin
            err_d = 1'b1;
          end
        end else if (expire_c) begin
          launch_c      = 1'b1;
          launch_word_c = word_q;
        end
        if (launch_c) begin
          shift_d = launch_word_c;
          sdo_d   = launch_word_c[FRM_W-1];
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (div_q == DIV_W'(HALF_PERIOD - 1)) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          div_d = DIV_W'(div_q + 1'b1);
        end
      end

      SHIFT_HI: begin
        if (div_q == DIV_W'(HALF_PERIOD - 1)) begin
          div_d  = '0;
          sclk_d = 1'b0;
          bit_d  = BIT_W'(bit_q + 1'b1);
          // Next bit is presented on the same edge sclk falls.
          if (bit_q < BIT_W'(FRM_W - 1)) begin
            shift_d = {shift_q[FRM_W-2:0], 1'b0};
            sdo_d   = shift_q[FRM_W-2];
            state_d = SHIFT_LO;
          end else begin
            sdo_d   = 1'b0;
            gap_d   = '0;
            state_d = GAP;
          end
        end else begin
          div_d = DIV_W'(div_q + 1'b1);
        end
      end

      GAP: begin
        // done occupies the final GAP cycle; ready returns the cycle after.
        if (gap_q == GAP_W'(GAP_CYCLES)) begin
          state_d = IDLE;
        end else begin
          gap_d = GAP_W'(gap_q + 1'b1);
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.sclk  = sclk_q;
  assign bus.sdo   = sdo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_spi_time_transmitter.sv
// Randomized self-checking bench for spi_time_transmitter; frames are decoded
// from the SPI pins and compared with the packed record computed arithmetically.
module tb_spi_time_transmitter;

  localparam int unsigned HP        = 2;
  localparam int unsigned GAPC      = 8;
  localparam int unsigned RP        = 50;
  localparam int unsigned FRAME_LEN = 1 + 64 * HP + GAPC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  spi_time_if bus ();

  always #5 clk = ~clk;

  spi_time_transmitter #(
    .HALF_PERIOD  (HP),
    .GAP_CYCLES   (GAPC),
    .REPEAT_PERIOD(RP)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Pin monitor: captures sdo at every sclk rise and flags protocol violations.
  int          rise_total = 0;
  logic [31:0] cap        = '0;
  int          stab_bad   = 0;
  int          hilen_bad  = 0;
  int          hi_len     = 0;
  logic        prev_sclk  = 1'b0;
  logic        prev_sdo   = 1'b0;
  bit          mon_en     = 1'b1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.sclk && !prev_sclk) begin
        rise_total++;
        cap = {cap[30:0], bus.sdo};
      end
      if ((bus.sdo !== prev_sdo) && bus.sclk) stab_bad++;
      if (!bus.sclk && prev_sclk && (hi_len != int'(HP))) hilen_bad++;
    end
    hi_len    = bus.sclk ? hi_len + 1 : 0;
    prev_sclk = bus.sclk;
    prev_sdo  = bus.sdo;
  end

  function automatic logic [31:0] pack(input int unsigned h, y, mo, d, hr, mi, s);
    int unsigned w;
    w = h * 32'h8000_0000 + y * (1 << 26) + mo * (1 << 22) + d * (1 << 17)
      + hr * (1 << 12) + mi * (1 << 6) + s;
    return 32'(w);
  endfunction

  function automatic bit is_valid(input int unsigned mo, d, hr, mi, s);
    return (mo >= 1) && (mo <= 12) && (d >= 1) && (d <= 31) &&
           (hr <= 23) && (mi <= 59) && (s <= 59);
  endfunction

  task automatic drive(input int unsigned h, y, mo, d, hr, mi, s);
    bus.header = 1'(h);
    bus.year   = 5'(y);
    bus.month  = 4'(mo);
    bus.day    = 5'(d);
    bus.hour   = 5'(hr);
    bus.minute = 6'(mi);
    bus.second = 6'(s);
  endtask

  // Issues one request in the current cycle; for valid requests returns at the done cycle.
  task automatic run_frame(input int unsigned h, y, mo, d, hr, mi, s,
                           input string tag, input bit poke);
    int          n;
    int          r0;
    logic [31:0] exp_word;
    exp_word = pack(h, y, mo, d, hr, mi, s);
    drive(h, y, mo, d, hr, mi, s);
    bus.start = 1'b1;
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    r0 = rise_total;
    @(negedge clk);
    n = 1;
    bus.start = 1'b0;
    if (is_valid(mo, d, hr, mi, s)) begin
      chk({tag, "_err"}, 32'(bus.err), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      while (!bus.done && n < int'(FRAME_LEN) + 50) begin
        @(negedge clk);
        n++;
        if (poke && n == 40) begin
          bus.start  = 1'b1;
          bus.second = 6'($urandom_range(59, 0));
          bus.header = ~bus.header;
        end else if (poke && n == 41) begin
          bus.start = 1'b0;
        end
      end
      chk({tag, "_lat"}, 32'(n), 32'(FRAME_LEN));
      chk({tag, "_word"}, cap, exp_word);
      chk({tag, "_rises"}, 32'(rise_total - r0), 32'd32);
    end else begin
      chk({tag, "_err"}, 32'(bus.err), 32'd1);
      @(negedge clk);
      chk({tag, "_err1"}, 32'(bus.err), 32'd0);
      chk({tag, "_idle"}, 32'({bus.ready, bus.busy, bus.sclk}), 32'b100);
    end
  endtask

  task automatic quiet(input int cycles, input string tag);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.sclk !== 1'b0 || bus.ready !== 1'b1) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic rand_valid(output int unsigned h, y, mo, d, hr, mi, s);
    h  = $urandom_range(1, 0);
    y  = $urandom_range(31, 0);
    mo = $urandom_range(12, 1);
    d  = $urandom_range(31, 1);
    hr = $urandom_range(23, 0);
    mi = $urandom_range(59, 0);
    s  = $urandom_range(59, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h, y, mo, d, hr, mi, s;
    int          n, r0, rc;
    logic        ps;
    logic [31:0] w;

    bus.start = 1'b0;
    drive(0, 0, 1, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({bus.sclk, bus.sdo, bus.busy, bus.done, bus.err}), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    run_frame(1, 14, 13, 2, 1, 20, 0, "inv_month", 1'b0);
    quiet(200, "inv_month_quiet");
    run_frame(1, 14, 10, 2, 1, 60, 0, "inv_minute", 1'b0);
    quiet(200, "inv_minute_quiet");

    run_frame(1, 14, 10, 2, 1, 20, 0, "directed", 1'b0);
    chk("directed_const", cap, 32'hBA84_1500);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      rand_valid(h, y, mo, d, hr, mi, s);
      run_frame(h, y, mo, d, hr, mi, s, $sformatf("rnd%0d", i), (i % 2) == 1);
      repeat ($urandom_range(4, 1)) @(negedge clk);
    end

    for (int i = 0; i < 4; i++) begin
      rand_valid(h, y, mo, d, hr, mi, s);
      case (i)
        0: mo = $urandom_range(1, 0) ? 0 : $urandom_range(15, 13);
        1: d  = 0;
        2: hr = $urandom_range(31, 24);
        default: s = $urandom_range(63, 60);
      endcase
      run_frame(h, y, mo, d, hr, mi, s, $sformatf("rinv%0d", i), 1'b0);
    end

    // start held high: second accept lands the cycle after done
    rand_valid(h, y, mo, d, hr, mi, s);
    drive(h, y, mo, d, hr, mi, s);
    bus.start = 1'b1;
    n = 0;
    while (!bus.done && n < int'(FRAME_LEN) + 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat0", 32'(n), 32'(FRAME_LEN));
    @(negedge clk);
    chk("b2b_acc_ready", 32'(bus.ready), 32'd1);
    r0 = rise_total;
    @(negedge clk);
    chk("b2b_busy", 32'({bus.busy, bus.ready}), 32'b10);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < int'(FRAME_LEN) + 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat1", 32'(n), 32'(FRAME_LEN));
    chk("b2b_word", cap, pack(h, y, mo, d, hr, mi, s));
    chk("b2b_rises", 32'(rise_total - r0), 32'd32);
    @(negedge clk);

    // reset at the 10th sclk rise
    rand_valid(h, y, mo, d, hr, mi, s);
    drive(h, y, mo, d, hr, mi, s);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rc = 0;
    ps = 1'b0;
    n  = 0;
    while (rc < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.sclk && !ps) rc++;
      ps = bus.sclk;
    end
    chk("rst_rise10", 32'(rc), 32'd10);
    reset  = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    chk("midrst_outs", 32'({bus.sclk, bus.sdo, bus.busy, bus.ready}), 32'b0001);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    rand_valid(h, y, mo, d, hr, mi, s);
    run_frame(h, y, mo, d, hr, mi, s, "post_rst", 1'b0);
    w = pack(h, y, mo, d, hr, mi, s);

`ifdef REPEAT_EN
    r0 = rise_total;
    n  = 0;
    while (!bus.sclk && n < int'(RP) + 100) begin
      @(negedge clk);
      n++;
    end
    chk("rep_first_rise", 32'(n), 32'(RP + 1 + HP));
    while (!bus.done && n < int'(RP + FRAME_LEN) + 100) begin
      @(negedge clk);
      n++;
    end
    chk("rep_lat", 32'(n), 32'(RP + FRAME_LEN));
    chk("rep_word", cap, w);
    chk("rep_rises", 32'(rise_total - r0), 32'd32);
    repeat (RP) @(negedge clk);
    rand_valid(h, y, mo, d, hr, mi, s);
    run_frame(h, y, mo, d, hr, mi, s, "rep_race", 1'b0);
`else
    r0 = rise_total;
    @(negedge clk);
    quiet(int'(RP) * 3, "norep_quiet");
    chk("norep_rises", 32'(rise_total - r0), 32'd0);
    chk("norep_word", cap, w);
`endif

    chk("sdo_stable", 32'(stab_bad), 32'd0);
    chk("sclk_hi_len", 32'(hilen_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_time_transmitter.md
Name: spi_time_transmitter

Overview:
SPI master that packs a time/date record into the 32-bit clock-sync frame and shifts it out MSB-first on sclk/sdo.
- Drives the VGA-side SPI receiver directly.
- Also serves as the bench model of the PIC.
- No chip-select: the receiver frames purely by counting 32 sclk cycles, so every transmission is exactly 32 full sclk periods.
- sclk idles low; sdo changes only while sclk is low and is stable at every sclk rising edge.

Parameters:
HALF_PERIOD, 4, clk cycles per sclk half-period (≥1)
GAP_CYCLES, 8, idle clk cycles with sclk low after a frame before ready returns high (≥1)
REPEAT_PERIOD, 1024, clk cycles of idle before an automatic resend (REPEAT_EN only, ≥1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted when start && ready
ready  output  1  high in IDLE
header  input  1  frame bit 31 (1 = syncing, 0 = last-good time)
year  input  5  years since 2000, bits 30:26
month  input  4  1..12, bits 25:22
day  input  5  1..31, bits 21:17
hour  input  5  0..23, bits 16:12, sent raw
minute  input  6  0..59, bits 11:6
second  input  6  0..59, bits 5:0
sclk  output  1  SPI clock, idle low
sdo  output  1  serial data to receiver sdi
busy  output  1  high in SHIFT or GAP
done  output  1  one-cycle pulse when GAP ends
err  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset values: sclk=0, sdo=0, busy=0, done=0, err=0, ready=1, state IDLE, shift register 0, bit counter 0, divider 0.
- Reset is synchronous and takes priority in any state. A frame aborted mid-shift leaves the receiver's bit counter misaligned; recovery is the system's job, not this block's.
- Fields are sampled only on the accept cycle. Later input changes do not affect an in-flight frame.
- Validation on accept:
  - Valid: 1≤month≤12, 1≤day≤31, hour≤23, minute≤59, second≤59.
  - Invalid: err pulses the next cycle, state stays IDLE, nothing is sent, latched word is unchanged.
- States:
  - IDLE: ready=1.
    - Valid accept: word={header,year,month,day,hour,minute,second} is latched; sdo=word[31] the next cycle; sclk stays low; go to SHIFT_LO.
  - SHIFT_LO: sclk=0 for HALF_PERIOD cycles, then sclk rises; go to SHIFT_HI.
  - SHIFT_HI: sclk=1 for HALF_PERIOD cycles, then sclk falls.
    - Bit counter increments on each fall.
    - If the counter was below 31: shift left, sdo takes the next bit in the same cycle sclk falls, return to SHIFT_LO.
    - After the 32nd fall: sdo=0, go to GAP.
  - GAP: sclk=0 for GAP_CYCLES cycles, then done pulses for 1 cycle and the state returns to IDLE.
- start during SHIFT or GAP is ignored. It is not queued.
- Frame length from accept to done: 1 + 64·HALF_PERIOD + GAP_CYCLES cycles. Exactly 32 sclk rising edges per frame.
- The receiver commits a frame on the first sclk rising edge of the following frame. A single frame therefore becomes visible only when the next one starts.

Optional Feature:
- REPEAT_EN defined:
  - Once at least one valid frame has been sent, an idle timer counts clk cycles in IDLE.
  - When it reaches REPEAT_PERIOD with no accept, the last latched word is resent exactly as a normal frame, and done pulses at the end.
  - A start arriving on the same cycle the timer expires wins: the new word is sent and the timer clears.
  - The timer clears on any accept, including rejected requests.
  - This periodically commits the latest time at the receiver.
- REPEAT_EN undefined: the timer logic is absent; frames are sent only on start.

Test Plan:
- HALF_PERIOD=2, GAP_CYCLES=8. Start with header=1, year=14, month=10, day=2, hour=1, minute=20, second=0 → sdo bits sampled at 32 sclk rises = 0xBA841500; done pulses 137 cycles after accept.
- Check sdo stability: sdo toggles only on clk cycles where sclk=0, never within a high phase. sclk high phases last exactly 2 cycles.
- Invalid input: month=13, or separately minute=60 → err pulses once, sclk stays 0 for 200 cycles, ready stays 1.
- Back-to-back: start held high continuously → second accept occurs the cycle after done; start pulsed mid-frame → ignored, exactly 32 rises.
- Assert reset at sclk rise #10 → the next cycle shows sclk=0, sdo=0, busy=0, ready=1. A fresh frame afterward is bit-exact.
- REPEAT_EN, REPEAT_PERIOD=50: one valid frame, then idle → identical frame restarts 50 cycles after done. start on the expiry cycle → the new word is sent.
